// File: rtl/ex_operand_stage.sv
// ex_operand_stage: ID/EX pipeline register feeding the ALU.
// Captures decoded fields each cycle, supports stall (hold) and flush
// (bubble), and forwards EX/MEM and MEM/WB results into A, B and the
// store-data path.
// Optional build macro: ILLEGAL_OP_TRAP_EN traps unknown ALU codes.
//
// Flow control: the stage has no ready output. Upstream must keep
// presenting the same ID fields while stall is high; flush overrides
// stall and drops the occupant; ex_valid marks a real instruction.
module ex_operand_stage #(
    parameter logic [3:0] BUBBLE_ALU_CTRL = 4'b0010
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        id_valid,
    input  logic [31:0] id_rs_data,
    input  logic [31:0] id_rt_data,
    input  logic [15:0] id_imm16,
    input  logic [4:0]  id_shamt,
    input  logic [14:0] id_regs,
    input  logic [3:0]  id_alu_control,
    input  logic [7:0]  id_ctrl,
    input  logic        exmem_reg_write,
    input  logic [4:0]  exmem_rd,
    input  logic [31:0] exmem_result,
    input  logic        memwb_reg_write,
    input  logic [4:0]  memwb_rd,
    input  logic [31:0] memwb_result,
    output logic        ex_valid,
    output logic [31:0] A,
    output logic [31:0] B,
    output logic [3:0]  ALU_control,
    output logic [31:0] ex_store_data,
    output logic [4:0]  ex_dest,
    output logic [3:0]  ex_ctrl,
    output logic        ex_illegal_op
);

    typedef struct packed {
        logic        valid;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [15:0] imm16;
        logic [4:0]  shamt;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  dest;
        logic [3:0]  alu_control;
        logic        alu_src;
        logic        shift_src;
        logic        ext_zero;
        logic [3:0]  ctrl;
`ifdef ILLEGAL_OP_TRAP_EN
        logic        illegal;
`endif
    } stage_t;

    stage_t stage_q;
    stage_t stage_d;
    stage_t bubble_s;
    stage_t load_s;

    logic [31:0] fwd_rs;
    logic [31:0] fwd_rt;
    logic [31:0] ext_imm;

    // Bubble value and the image of the incoming ID instruction.
    always_comb begin
        bubble_s             = '0;
        bubble_s.alu_control = BUBBLE_ALU_CTRL;

        load_s             = '0;
        load_s.valid       = 1'b1;
        load_s.rs_data     = id_rs_data;
        load_s.rt_data     = id_rt_data;
        load_s.imm16       = id_imm16;
        load_s.shamt       = id_shamt;
        load_s.rs          = id_regs[14:10];
        load_s.rt          = id_regs[9:5];
        load_s.dest        = id_ctrl[4] ? id_regs[4:0] : id_regs[9:5];
        load_s.alu_control = id_alu_control;
        load_s.alu_src     = id_ctrl[7];
        load_s.shift_src   = id_ctrl[6];
        load_s.ext_zero    = id_ctrl[5];
        load_s.ctrl        = id_ctrl[3:0];
`ifdef ILLEGAL_OP_TRAP_EN
        // Unknown opcodes travel as a harmless ADD with no side effects.
        if (!(id_alu_control inside {4'b0000, 4'b0001, 4'b0010, 4'b0011,
                                     4'b0100, 4'b0101, 4'b0110, 4'b0111,
                                     4'b1100})) begin
            load_s.ctrl        = 4'b0000;
            load_s.alu_control = BUBBLE_ALU_CTRL;
            load_s.illegal     = 1'b1;
        end
`endif
    end

    // Next-state selection: flush beats stall, stall beats load.
    always_comb begin
        stage_d = stage_q;
        if (flush) begin
            stage_d = bubble_s;
        end else if (stall) begin
            stage_d = stage_q;
        end else if (id_valid) begin
            stage_d = load_s;
        end else begin
            stage_d = bubble_s;
        end
    end

    // Stage register; reset discards any held instruction.
    always_ff @(posedge clk) begin
        if (reset) begin
            stage_q <= bubble_s;
        end else begin
            stage_q <= stage_d;
        end
    end

    // Forwarding from the registered rs/rt; re-evaluated during stall
    // because the producers keep advancing.
    always_comb begin
        if (exmem_reg_write && (exmem_rd == stage_q.rs) && (stage_q.rs != 5'd0)) begin
            fwd_rs = exmem_result;
        end else if (memwb_reg_write && (memwb_rd == stage_q.rs) && (stage_q.rs != 5'd0)) begin
            fwd_rs = memwb_result;
        end else begin
            fwd_rs = stage_q.rs_data;
        end

        if (exmem_reg_write && (exmem_rd == stage_q.rt) && (stage_q.rt != 5'd0)) begin
            fwd_rt = exmem_result;
        end else if (memwb_reg_write && (memwb_rd == stage_q.rt) && (stage_q.rt != 5'd0)) begin
            fwd_rt = memwb_result;
        end else begin
            fwd_rt = stage_q.rt_data;
        end
    end

    // Operand selection feeding the ALU and the store path.
    always_comb begin
        ext_imm       = stage_q.ext_zero ? {16'h0000, stage_q.imm16}
                                         : {{16{stage_q.imm16[15]}}, stage_q.imm16};
        A             = stage_q.shift_src ? {27'b0, stage_q.shamt} : fwd_rs;
        B             = stage_q.alu_src ? ext_imm : fwd_rt;
        ex_store_data = fwd_rt;
        ex_valid      = stage_q.valid;
        ALU_control   = stage_q.alu_control;
        ex_dest       = stage_q.dest;
        ex_ctrl       = stage_q.ctrl;
`ifdef ILLEGAL_OP_TRAP_EN
        ex_illegal_op = stage_q.illegal;
`else
        ex_illegal_op = 1'b0;
`endif
    end

endmodule

// File: tb/tb_ex_operand_stage.sv
// tb_ex_operand_stage: directed vectors for ex_operand_stage with a
// queue-based scoreboard checked by an independent monitor.
module tb_ex_operand_stage;

    localparam int W = 111;

    logic        clk = 1'b0;
    logic        reset, stall, flush, id_valid;
    logic [31:0] id_rs_data, id_rt_data;
    logic [15:0] id_imm16;
    logic [4:0]  id_shamt;
    logic [14:0] id_regs;
    logic [3:0]  id_alu_control;
    logic [7:0]  id_ctrl;
    logic        exmem_reg_write, memwb_reg_write;
    logic [4:0]  exmem_rd, memwb_rd;
    logic [31:0] exmem_result, memwb_result;
    logic        ex_valid, ex_illegal_op;
    logic [31:0] A, B, ex_store_data;
    logic [3:0]  ALU_control, ex_ctrl;
    logic [4:0]  ex_dest;

    logic [W-1:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    ex_operand_stage dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .id_valid(id_valid), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
        .id_imm16(id_imm16), .id_shamt(id_shamt), .id_regs(id_regs),
        .id_alu_control(id_alu_control), .id_ctrl(id_ctrl),
        .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd),
        .exmem_result(exmem_result), .memwb_reg_write(memwb_reg_write),
        .memwb_rd(memwb_rd), .memwb_result(memwb_result),
        .ex_valid(ex_valid), .A(A), .B(B), .ALU_control(ALU_control),
        .ex_store_data(ex_store_data), .ex_dest(ex_dest), .ex_ctrl(ex_ctrl),
        .ex_illegal_op(ex_illegal_op)
    );

    // Clock and overall time bound.
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    function automatic logic [W-1:0] mk(input logic v, input logic [31:0] a,
                                        input logic [31:0] b, input logic [3:0] alu,
                                        input logic [31:0] st, input logic [4:0] dst,
                                        input logic [3:0] ctl, input logic ill);
        return {v, a, b, alu, st, dst, ctl, ill};
    endfunction

    // Monitor: outputs are stable mid-cycle, so compare on the falling edge.
    always @(negedge clk) begin
        logic [W-1:0] exp_v;
        logic [W-1:0] act_v;
        if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            act_v = {ex_valid, A, B, ALU_control, ex_store_data, ex_dest, ex_ctrl, ex_illegal_op};
            n_checks++;
            if (act_v !== exp_v) begin
                n_fail++;
                $display("FAIL check%0d {valid,A,B,alu,store,dest,ctrl,ill}: got v=%b A=%h B=%h alu=%b st=%h d=%0d c=%b i=%b, expected v=%b A=%h B=%h alu=%b st=%h d=%0d c=%b i=%b",
                         n_checks, act_v[110], act_v[109:78], act_v[77:46], act_v[45:42],
                         act_v[41:10], act_v[9:5], act_v[4:1], act_v[0],
                         exp_v[110], exp_v[109:78], exp_v[77:46], exp_v[45:42],
                         exp_v[41:10], exp_v[9:5], exp_v[4:1], exp_v[0]);
            end
        end
    end

    // Driver: present an ID instruction (captured on the next edge).
    task automatic set_id(input logic v, input logic [31:0] rsd, input logic [31:0] rtd,
                          input logic [15:0] imm, input logic [4:0] sh,
                          input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                          input logic [3:0] alu, input logic [7:0] ctl);
        id_valid       = v;
        id_rs_data     = rsd;
        id_rt_data     = rtd;
        id_imm16       = imm;
        id_shamt       = sh;
        id_regs        = {rs, rt, rd};
        id_alu_control = alu;
        id_ctrl        = ctl;
    endtask

    // Driver: one edge, then set the forwarding sources seen in the
    // following cycle and queue the outputs expected for that cycle.
    task automatic step(input logic ew, input logic [4:0] erd, input logic [31:0] eres,
                        input logic mw, input logic [4:0] mrd, input logic [31:0] mres,
                        input logic [W-1:0] exp_v);
        @(posedge clk);
        #1;
        exmem_reg_write = ew;
        exmem_rd        = erd;
        exmem_result    = eres;
        memwb_reg_write = mw;
        memwb_rd        = mrd;
        memwb_result    = mres;
        exp_q.push_back(exp_v);
    endtask

    logic [W-1:0] bub;

    initial begin
        bub = mk(1'b0, 32'h0, 32'h0, 4'b0010, 32'h0, 5'd0, 4'b0000, 1'b0);
        reset = 1'b1; stall = 1'b0; flush = 1'b0;
        exmem_reg_write = 1'b0; exmem_rd = 5'd0; exmem_result = 32'h0;
        memwb_reg_write = 1'b0; memwb_rd = 5'd0; memwb_result = 32'h0;
        set_id(1'b1, 32'h1234, 32'h5678, 16'h0, 5'd0, 5'd1, 5'd2, 5'd3, 4'b0010, 8'h18);

        // Reset state is a bubble even with a valid ID instruction.
        step(0, 0, 0, 0, 0, 0, bub);
        reset = 1'b0;

        // add $3,$1,$2
        set_id(1'b1, 32'd5, 32'd7, 16'h0, 5'd0, 5'd1, 5'd2, 5'd3, 4'b0010, 8'h18);
        step(0, 0, 0, 0, 0, 0, mk(1, 32'd5, 32'd7, 4'b0010, 32'd7, 5'd3, 4'b1000, 0));

        // Forwarding priority on rs=4
        set_id(1'b1, 32'h11, 32'h22, 16'h0, 5'd0, 5'd4, 5'd5, 5'd6, 4'b0010, 8'h18);
        step(1, 5'd4, 32'hAA, 1, 5'd4, 32'hBB, mk(1, 32'hAA, 32'h22, 4'b0010, 32'h22, 5'd6, 4'b1000, 0));
        stall = 1'b1;
        step(0, 5'd4, 32'hAA, 1, 5'd4, 32'hBB, mk(1, 32'hBB, 32'h22, 4'b0010, 32'h22, 5'd6, 4'b1000, 0));
        step(1, 5'd5, 32'h33, 0, 5'd4, 32'hBB, mk(1, 32'h11, 32'h33, 4'b0010, 32'h33, 5'd6, 4'b1000, 0));
        stall = 1'b0;

        // $0 is never forwarded
        set_id(1'b1, 32'h44, 32'd9, 16'h0, 5'd0, 5'd0, 5'd2, 5'd7, 4'b0010, 8'h18);
        step(1, 5'd0, 32'hDEAD, 1, 5'd0, 32'hBEEF, mk(1, 32'h44, 32'd9, 4'b0010, 32'd9, 5'd7, 4'b1000, 0));

        // addi sign-extends, ori zero-extends
        set_id(1'b1, 32'd10, 32'h55, 16'hFFFF, 5'd0, 5'd1, 5'd8, 5'd0, 4'b0010, 8'h88);
        step(0, 0, 0, 0, 0, 0, mk(1, 32'd10, 32'hFFFF_FFFF, 4'b0010, 32'h55, 5'd8, 4'b1000, 0));
        set_id(1'b1, 32'd10, 32'h55, 16'hFFFF, 5'd0, 5'd1, 5'd8, 5'd0, 4'b0001, 8'hA8);
        step(0, 0, 0, 0, 0, 0, mk(1, 32'd10, 32'h0000_FFFF, 4'b0001, 32'h55, 5'd8, 4'b1000, 0));

        // sll shamt=4 with rt forwarded from MEM/WB
        set_id(1'b1, 32'h0, 32'h0F, 16'h0, 5'd4, 5'd0, 5'd2, 5'd9, 4'b0100, 8'h58);
        step(0, 0, 0, 1, 5'd2, 32'h77, mk(1, 32'd4, 32'h77, 4'b0100, 32'h77, 5'd9, 4'b1000, 0));

        // sw: store data forwarded while B is the immediate
        set_id(1'b1, 32'h100, 32'h12, 16'd8, 5'd0, 5'd1, 5'd3, 5'd0, 4'b0010, 8'h82);
        step(1, 5'd3, 32'h99, 0, 0, 0, mk(1, 32'h100, 32'd8, 4'b0010, 32'h99, 5'd3, 4'b0010, 0));

        // Stall 3 cycles; A tracks the EX/MEM result while fields hold
        set_id(1'b1, 32'h50, 32'h0, 16'h0, 5'd0, 5'd4, 5'd0, 5'd5, 4'b0010, 8'h18);
        step(0, 0, 0, 0, 0, 0, mk(1, 32'h50, 32'h0, 4'b0010, 32'h0, 5'd5, 4'b1000, 0));
        stall = 1'b1;
        set_id(1'b1, 32'hFF, 32'hEE, 16'h1, 5'd1, 5'd6, 5'd7, 5'd8, 4'b0110, 8'h18);
        for (int k = 1; k <= 3; k++) begin
            step(1, 5'd4, 32'(k), 0, 0, 0, mk(1, 32'(k), 32'h0, 4'b0010, 32'h0, 5'd5, 4'b1000, 0));
        end

        // Stall and flush together -> bubble
        flush = 1'b1;
        step(1, 5'd4, 32'd3, 0, 0, 0, bub);
        flush = 1'b0; stall = 1'b0;

        // Reset mid-stall discards the held instruction
        set_id(1'b1, 32'h50, 32'h0, 16'h0, 5'd0, 5'd4, 5'd0, 5'd5, 4'b0010, 8'h18);
        step(0, 0, 0, 0, 0, 0, mk(1, 32'h50, 32'h0, 4'b0010, 32'h0, 5'd5, 4'b1000, 0));
        stall = 1'b1; reset = 1'b1;
        step(0, 0, 0, 0, 0, 0, bub);
        stall = 1'b0; reset = 1'b0;

        // id_valid=0 loads a bubble
        set_id(1'b0, 32'h50, 32'h60, 16'h0, 5'd0, 5'd4, 5'd1, 5'd5, 4'b0110, 8'h18);
        step(0, 0, 0, 0, 0, 0, bub);

        // Destination $0 keeps its reg_write bit
        set_id(1'b1, 32'd1, 32'd2, 16'h0, 5'd0, 5'd1, 5'd2, 5'd0, 4'b0011, 8'h18);
        step(0, 0, 0, 0, 0, 0, mk(1, 32'd1, 32'd2, 4'b0011, 32'd2, 5'd0, 4'b1000, 0));

        // ALU code 1000: trapped when the feature is built in, else passed through
        set_id(1'b1, 32'd3, 32'd4, 16'h0, 5'd0, 5'd1, 5'd2, 5'd3, 4'b1000, 8'h18);
`ifdef ILLEGAL_OP_TRAP_EN
        step(0, 0, 0, 0, 0, 0, mk(1, 32'd3, 32'd4, 4'b0010, 32'd4, 5'd3, 4'b0000, 1));
        stall = 1'b1;
        step(0, 0, 0, 0, 0, 0, mk(1, 32'd3, 32'd4, 4'b0010, 32'd4, 5'd3, 4'b0000, 1));
`else
        step(0, 0, 0, 0, 0, 0, mk(1, 32'd3, 32'd4, 4'b1000, 32'd4, 5'd3, 4'b1000, 0));
        stall = 1'b1;
        step(0, 0, 0, 0, 0, 0, mk(1, 32'd3, 32'd4, 4'b1000, 32'd4, 5'd3, 4'b1000, 0));
`endif
        stall = 1'b0;

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
